ppm_draw_controller: RTL and testbench
======================================

// Module: ppm_draw_controller
// PURPOSE
//   Command sequencer in front of the PPM framebuffer MMIO sink. Accepts one drawing
//   command at a time (pixel, rectangle fill, full clear, present). Expands each command
//   into a row-major stream of single-pixel writes on the framebuffer valid/ready port.
//   PRESENT issues a one-cycle dump strobe once every earlier write has been accepted.
//   Sits between the core's MMIO decode and the framebuffer sink.
// PARAMETERS
//   ADDR_WIDTH    17   framebuffer word address width (must hold FRAME_WIDTH*FRAME_HEIGHT-1)
//   DATA_WIDTH    24   pixel width, {R[23:16],G[15:8],B[7:0]}
//   FRAME_WIDTH   320  pixels per row
//   FRAME_HEIGHT  240  rows per frame
// PORTS
//   clock         in   1           single clock, all logic on posedge
//   reset         in   1           synchronous, active-high
//   cmd_valid     in   1           command offered
//   cmd_ready     out  1           command accepted when cmd_valid & cmd_ready
//   cmd_op        in   2           0=PIXEL 1=FILL 2=CLEAR 3=PRESENT
//   cmd_x         in   9           left column
//   cmd_y         in   8           top row
//   cmd_w         in   9           FILL width in pixels
//   cmd_h         in   8           FILL height in pixels
//   cmd_color     in   DATA_WIDTH  pixel value
//   fb_valid      out  1           write beat offered to framebuffer
//   fb_ready      in   1           framebuffer accepts beat
//   fb_address    out  ADDR_WIDTH  y*FRAME_WIDTH + x
//   fb_data       out  DATA_WIDTH  pixel value
//   fb_operation  out  1           write enable; equals fb_valid
//   fb_dump       out  1           one-cycle dump strobe
//   busy          out  1           state != IDLE
//   err_clip      out  1           one-cycle pulse: command clipped or rejected
// BEHAVIOUR
//   Reset (sync): state=IDLE. fb_valid, fb_dump, err_clip, busy = 0.
//     cmd_ready forced 0 while reset is high.
//   Reset mid-operation: remaining pixels are dropped. No dump is issued.
//     Outputs are 0 in the cycle after reset is sampled.
//   FSM: IDLE -> DRAW (PIXEL/FILL/CLEAR with >=1 pixel) | DUMP (PRESENT). DRAW -> IDLE
//     after last beat handshake; DUMP -> IDLE after exactly one cycle.
//   cmd_ready = (state==IDLE) & !reset. Commands are never queued; fields are latched on accept.
//   PIXEL is treated as FILL with w=1, h=1. CLEAR is treated as FILL x=0,y=0,w=FRAME_WIDTH,h=FRAME_HEIGHT.
//   Clipping:
//     Reject (no writes, err_clip pulse, stay IDLE) when any of these hold:
//       x>=FRAME_WIDTH, y>=FRAME_HEIGHT, w==0, h==0.
//     Otherwise x_end=min(x+w,FRAME_WIDTH), y_end=min(y+h,FRAME_HEIGHT).
//       Sums are computed 1 bit wider, with no wrap.
//     If either end is truncated, err_clip pulses in the cycle after accept and drawing proceeds.
//   Latency: first fb_valid in the cycle after the accept. Beats are row-major, x fastest.
//   Handshake: once fb_valid is high, it and fb_address/fb_data hold stable until fb_ready.
//     A beat transfers on fb_valid & fb_ready.
//     With fb_ready held high, throughput is 1 pixel/cycle and there are no bubbles between beats.
//     fb_ready may toggle arbitrarily.
//   Address: running counter (+1 per beat, +FRAME_WIDTH-span at row end). No multiplier in the beat path.
//   PRESENT: the FSM is serial, so all prior writes are already accepted.
//     fb_dump=1 for exactly one cycle, with fb_valid=0. Back to IDLE.
//   fb_dump and fb_valid are never high together.
//   Commands offered while busy are ignored. cmd_valid must hold until accepted.
// TESTING
//   1. PIXEL x=5,y=2,color=0x123456, fb_ready=1 -> one beat addr 645, data 0x123456;
//      busy low and cmd_ready high the next cycle.
//   2. FILL x=10,y=0,w=3,h=2, fb_ready toggling 1/0 -> addresses 10,11,12,330,331,332.
//      Exactly 6 handshakes; addr/data stable while ready is low.
//   3. FILL x=318,y=239,w=4,h=2 -> err_clip pulse; writes 76798,76799 only.
//      FILL w=0 -> err_clip pulse, no fb_valid.
//   4. CLEAR color=0x000000, fb_ready=1 -> 76800 back-to-back beats, addresses 0..76799,
//      then IDLE.
//   5. FILL 2x2 then PRESENT with fb_ready stalling -> fb_dump single-cycle pulse strictly
//      after the 4th handshake. A PRESENT held during DRAW is not accepted early.
//   6. reset asserted at beat 100 of CLEAR -> next cycle fb_valid=0, busy=0, fb_dump=0.
//      A following PIXEL command draws correctly.

Source files
------------

// File: rtl/ppm_draw_controller.sv
// Command sequencer for the PPM framebuffer: expands pixel/fill/clear commands into
// row-major single-pixel write beats and turns PRESENT into a one-cycle dump strobe.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// DRAW   | streaming clipped rectangle beats to the framebuffer
// DUMP   | one-cycle fb_dump strobe, then back to IDLE
module ppm_draw_controller #(
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_WIDTH   = 24,
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 240
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [8:0]            cmd_x,
  input  logic [7:0]            cmd_y,
  input  logic [8:0]            cmd_w,
  input  logic [7:0]            cmd_h,
  input  logic [DATA_WIDTH-1:0] cmd_color,
  output logic                  fb_valid,
  input  logic                  fb_ready,
  output logic [ADDR_WIDTH-1:0] fb_address,
  output logic [DATA_WIDTH-1:0] fb_data,
  output logic                  fb_operation,
  output logic                  fb_dump,
  output logic                  busy,
  output logic                  err_clip
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DUMP = 2'd2;

  localparam logic [1:0] OP_PIXEL   = 2'd0;
  localparam logic [1:0] OP_FILL    = 2'd1;
  localparam logic [1:0] OP_CLEAR   = 2'd2;
  localparam logic [1:0] OP_PRESENT = 2'd3;

  localparam logic [9:0] FW = 10'(FRAME_WIDTH);
  localparam logic [8:0] FH = 9'(FRAME_HEIGHT);

  logic [1:0]            state;
  logic [9:0]            cur_x, x_first, x_last;
  logic [8:0]            cur_y, y_last;
  logic [ADDR_WIDTH-1:0] addr_q, row_step;
  logic [DATA_WIDTH-1:0] color_q;
  logic                  clip_q;

  logic [9:0]            eff_x, eff_w, x_sum, x_end, span;
  logic [8:0]            eff_y, eff_h, y_sum, y_end;
  logic                  reject, x_trunc, y_trunc;
  logic [ADDR_WIDTH-1:0] start_addr, step_calc;

  // Normalise every drawing command to a rectangle, then clip it against the frame.
  always_comb begin
    eff_x = {1'b0, cmd_x};
    eff_y = {1'b0, cmd_y};
    eff_w = {1'b0, cmd_w};
    eff_h = {1'b0, cmd_h};
    case (cmd_op)
      OP_PIXEL: begin
        eff_w = 10'd1;
        eff_h = 9'd1;
      end
      OP_CLEAR: begin
        eff_x = 10'd0;
        eff_y = 9'd0;
        eff_w = FW;
        eff_h = FH;
      end
      default: ;
    endcase
    x_sum      = eff_x + eff_w;
    y_sum      = eff_y + eff_h;
    reject     = (eff_x >= FW) || (eff_y >= FH) || (eff_w == 10'd0) || (eff_h == 9'd0);
    x_trunc    = x_sum > FW;
    y_trunc    = y_sum > FH;
    x_end      = x_trunc ? FW : x_sum;
    y_end      = y_trunc ? FH : y_sum;
    span       = x_end - eff_x;
    // Multiply happens once per command at accept, never per beat.
    start_addr = ADDR_WIDTH'(eff_y) * ADDR_WIDTH'(FRAME_WIDTH) + ADDR_WIDTH'(eff_x);
    step_calc  = ADDR_WIDTH'(FRAME_WIDTH) - ADDR_WIDTH'(span) + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      clip_q   <= 1'b0;
      cur_x    <= '0;
      cur_y    <= '0;
      x_first  <= '0;
      x_last   <= '0;
      y_last   <= '0;
      addr_q   <= '0;
      row_step <= '0;
      color_q  <= '0;
    end else begin
      clip_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_op == OP_PRESENT) begin
              state <= S_DUMP;
            end else if (reject) begin
              clip_q <= 1'b1;
            end else begin
              clip_q   <= x_trunc | y_trunc;
              cur_x    <= eff_x;
              cur_y    <= eff_y;
              x_first  <= eff_x;
              x_last   <= x_end - 10'd1;
              y_last   <= y_end - 9'd1;
              addr_q   <= start_addr;
              row_step <= step_calc;
              color_q  <= cmd_color;
              state    <= S_DRAW;
            end
          end
        end
        S_DRAW: begin
          if (fb_ready) begin
            if (cur_x == x_last) begin
              if (cur_y == y_last) begin
                state <= S_IDLE;
              end else begin
                cur_x  <= x_first;
                cur_y  <= cur_y + 9'd1;
                addr_q <= addr_q + row_step;
              end
            end else begin
              cur_x  <= cur_x + 10'd1;
              addr_q <= addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        S_DUMP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (state == S_IDLE) & ~reset;
  assign fb_valid     = (state == S_DRAW);
  assign fb_operation = fb_valid;
  assign fb_address   = addr_q;
  assign fb_data      = color_q;
  assign fb_dump      = (state == S_DUMP);
  assign busy         = (state != S_IDLE);
  assign err_clip     = clip_q;

endmodule

// File: tb/tb_ppm_draw_controller.sv
// Directed bench for ppm_draw_controller: table of commands with hand-computed results,
// plus sequences for PRESENT ordering and reset in the middle of a CLEAR.
module tb_ppm_draw_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [23:0] cmd_color;
  logic        fb_valid;
  logic        fb_ready;
  logic [16:0] fb_address;
  logic [23:0] fb_data;
  logic        fb_operation;
  logic        fb_dump;
  logic        busy;
  logic        err_clip;

  int n_cmp  = 0;
  int n_fail = 0;

  ppm_draw_controller dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .fb_valid(fb_valid), .fb_ready(fb_ready),
    .fb_address(fb_address), .fb_data(fb_data), .fb_operation(fb_operation),
    .fb_dump(fb_dump), .busy(busy), .err_clip(err_clip)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    int          x, y, w, h;
    logic [23:0] color;
    int          rmode;      // 0 ready high, 1 ready toggling, 2 ready one cycle in four
    int          exp_beats;
    int          exp_last;
    int          exp_clip;
    int          exp_dump;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one command and watch the beat stream against a reference rectangle walk.
  task automatic run_cmd(input logic [1:0] op, input int x, input int y, input int w,
                         input int h, input logic [23:0] color, input int rmode,
                         output int beats, output int last, output int clips,
                         output int dumps, output int seq_err, output int timeout);
    int mx, my, mw, mh, xe, ye, ex, ey, cyc;
    bit r, stalled, done;
    logic [16:0] paddr;
    logic [23:0] pdata;
    beats = 0; last = -1; clips = 0; dumps = 0; seq_err = 0; timeout = 0;
    mx = x; my = y; mw = w; mh = h;
    if (op == 2'd0) begin mw = 1; mh = 1; end
    if (op == 2'd2) begin mx = 0; my = 0; mw = 320; mh = 240; end
    xe = (mx + mw > 320) ? 320 : mx + mw;
    ye = (my + mh > 240) ? 240 : my + mh;
    ex = mx; ey = my;
    cyc = 0;
    while (!cmd_ready && cyc < 100) begin @(negedge clock); cyc++; end
    cmd_op = op; cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h);
    cmd_color = color; cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    stalled = 0; done = 0; paddr = '0; pdata = '0;
    for (int c = 0; c < 90000 && !done; c++) begin
      case (rmode)
        1: r = (c % 2) == 0;
        2: r = (c % 4) == 3;
        default: r = 1'b1;
      endcase
      fb_ready = r;
      if (stalled && (!fb_valid || fb_address != paddr || fb_data != pdata)) seq_err++;
      if (err_clip) clips++;
      if (fb_dump) begin
        dumps++;
        if (fb_valid) seq_err++;
      end
      if (fb_operation != fb_valid) seq_err++;
      if (rmode == 0 && busy && op != 2'd3 && !fb_valid) seq_err++;
      if (fb_valid && r) begin
        if (fb_address != 17'(ey * 320 + ex) || fb_data != color) seq_err++;
        last = int'(fb_address);
        beats++;
        ex++;
        if (ex == xe) begin ex = mx; ey++; end
      end
      stalled = fb_valid && !r;
      paddr = fb_address;
      pdata = fb_data;
      if (!busy) done = 1;
      else @(negedge clock);
    end
    if (!done) timeout = 1;
    fb_ready = 1'b1;
  endtask

  initial begin
    int beats, last, clips, dumps, seq_err, timeout;
    int hs, early, cyc;
    bit done;

    vecs[0] = '{2'd0,   5,   2, 0, 0, 24'h123456, 0,     1,   645, 0, 0};
    vecs[1] = '{2'd1,  10,   0, 3, 2, 24'h00ff00, 1,     6,   332, 0, 0};
    vecs[2] = '{2'd1, 318, 239, 4, 2, 24'habcdef, 0,     2, 76799, 1, 0};
    vecs[3] = '{2'd1,  20,  20, 0, 5, 24'h111111, 0,     0,     0, 1, 0};
    vecs[4] = '{2'd1,   0,   0, 2, 2, 24'h445566, 2,     4,   321, 0, 0};
    vecs[5] = '{2'd3,   0,   0, 0, 0, 24'h000000, 0,     0,     0, 0, 1};
    vecs[6] = '{2'd0, 320,   0, 0, 0, 24'h777777, 0,     0,     0, 1, 0};
    vecs[7] = '{2'd0,   0, 240, 0, 0, 24'h888888, 0,     0,     0, 1, 0};
    vecs[8] = '{2'd1, 300, 230, 30, 20, 24'h0a0b0c, 1, 200, 76799, 1, 0};
    vecs[9] = '{2'd2,   0,   0, 0, 0, 24'h000000, 0, 76800, 76799, 0, 0};

    reset = 1'b1; fb_ready = 1'b1; cmd_valid = 1'b0;
    cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_fb_valid", fb_valid, 0);
    check("rst_fb_dump", fb_dump, 0);
    check("rst_err_clip", err_clip, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < NV; i++) begin
      run_cmd(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color,
              vecs[i].rmode, beats, last, clips, dumps, seq_err, timeout);
      check($sformatf("v%0d_timeout", i), timeout, 0);
      check($sformatf("v%0d_beats", i), beats, vecs[i].exp_beats);
      check($sformatf("v%0d_clip", i), clips, vecs[i].exp_clip);
      check($sformatf("v%0d_dump", i), dumps, vecs[i].exp_dump);
      check($sformatf("v%0d_stream", i), seq_err, 0);
      if (vecs[i].exp_beats > 0) check($sformatf("v%0d_last_addr", i), last, vecs[i].exp_last);
      check($sformatf("v%0d_ready_after", i), cmd_ready, 1);
    end

    // FILL 2x2 with stalls while a PRESENT is held on the command port.
    cmd_op = 2'd1; cmd_x = 9'd0; cmd_y = 8'd5; cmd_w = 9'd2; cmd_h = 8'd2;
    cmd_color = 24'h0abc00; cmd_valid = 1'b1;
    @(negedge clock);
    cmd_op = 2'd3;
    hs = 0; early = 0; dumps = 0; done = 0;
    for (cyc = 0; cyc < 200 && !done; cyc++) begin
      fb_ready = (cyc % 3) == 2;
      if (cmd_ready && hs < 4) early++;
      if (fb_dump) begin
        dumps++;
        if (hs != 4 || fb_valid) early++;
        cmd_valid = 1'b0;
      end
      if (fb_valid && fb_ready) hs++;
      if (dumps > 0 && !busy) done = 1;
      else @(negedge clock);
    end
    cmd_valid = 1'b0; fb_ready = 1'b1;
    check("present_done", done, 1);
    check("present_handshakes", hs, 4);
    check("present_dump_count", dumps, 1);
    check("present_early", early, 0);

    // Reset after 100 beats of a CLEAR, then a PIXEL must still draw correctly.
    @(negedge clock);
    cmd_op = 2'd2; cmd_color = 24'h123123; cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    hs = 0;
    for (cyc = 0; cyc < 300 && hs < 100; cyc++) begin
      if (fb_valid) hs++;
      @(negedge clock);
    end
    check("clear_hs_before_reset", hs, 100);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_fb_valid", fb_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_fb_dump", fb_dump, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    @(negedge clock);
    run_cmd(2'd0, 7, 3, 0, 0, 24'ha5a5a5, 0, beats, last, clips, dumps, seq_err, timeout);
    check("post_rst_timeout", timeout, 0);
    check("post_rst_beats", beats, 1);
    check("post_rst_addr", last, 967);
    check("post_rst_clip", clips, 0);
    check("post_rst_stream", seq_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
